// File: rtl/lfsr_pkg.sv
// Shared definitions for the 32-bit Fibonacci PRBS generator and checker.
// - N            : word width (fixed by the polynomial)
// - chk_state_t  : checker acquisition state
// - lfsr32_next  : one generator step, taps 31,30,26,23,20,0, shift toward bit 0
package lfsr_pkg;

  localparam int unsigned N = 32;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } chk_state_t;

  // Feedback enters at the MSB; the word shifts right by one each step.
  function automatic logic [31:0] lfsr32_next(input logic [31:0] q);
    logic fb;
    fb = q[31] ^ q[30] ^ q[26] ^ q[23] ^ q[20] ^ q[0];
    return {fb, q[31:1]};
  endfunction

endpackage

// File: rtl/popcount32.sv
// Combinational population count of a 32-bit word.
// - data_i  : word to count
// - count_o : number of set bits (0..32)
module popcount32 (
  input  logic [31:0] data_i,
  output logic [5:0]  count_o
);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < 32; i++) begin
      count_o = count_o + 6'(data_i[i]);
    end
  end

endmodule

// File: rtl/lfsr32_prbs_checker.sv
// Receive-side PRBS checker: self-synchronises to a stream from the 32-bit
// Fibonacci LFSR generator, then flywheels its own reference and counts errors.
// - CLK      : clock, rising edge
// - RST      : asynchronous reset, active-high
// - CLR_CNT  : synchronous clear of both error counters
// - DIN_VLD  : DIN carries one generator step this cycle
// - DIN      : received word
// - LOCKED   : checker is locked (registered)
// - ERR      : one-cycle pulse, last valid word mismatched while locked
// - ERR_WCNT : saturating count of mismatching words while locked
// - ERR_BCNT : saturating count of mismatching bits while locked
module lfsr32_prbs_checker #(
  parameter int unsigned N          = 32,
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned UNLOCK_CNT = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CLR_CNT,
  input  logic             DIN_VLD,
  input  logic [N-1:0]     DIN,
  output logic             LOCKED,
  output logic             ERR,
  output logic [CNT_W-1:0] ERR_WCNT,
  output logic [CNT_W-1:0] ERR_BCNT
);

  import lfsr_pkg::*;

  localparam int unsigned GOOD_W  = $clog2(LOCK_CNT + 1);
  localparam int unsigned BAD_W   = $clog2(UNLOCK_CNT + 1);
  // Adder must hold both the counter and a full 6-bit popcount before clamping.
  localparam int unsigned SUM_W   = ((CNT_W > 6) ? CNT_W : 6) + 1;
  localparam logic [CNT_W-1:0]  CNT_MAX    = '1;
  localparam logic [GOOD_W-1:0] LOCK_TGT   = GOOD_W'(LOCK_CNT);
  localparam logic [BAD_W-1:0]  UNLOCK_TGT = BAD_W'(UNLOCK_CNT);

  // Only the 32-bit polynomial exists.
  if (N != 32) begin : g_bad_width
    $error("lfsr32_prbs_checker supports N=32 only");
  end

  chk_state_t        state_q, state_d;
  logic [31:0]       exp_q, exp_d;
  logic [GOOD_W-1:0] good_q, good_d;
  logic [BAD_W-1:0]  bad_q, bad_d;
  logic              locked_q, locked_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  wcnt_q, wcnt_d;
  logic [CNT_W-1:0]  bcnt_q, bcnt_d;

  logic [31:0]       din_w;
  logic [31:0]       diff_w;
  logic [5:0]        diff_bits;
  logic              match_w;
  logic              din_zero;
  logic [GOOD_W-1:0] good_inc;
  logic [BAD_W-1:0]  bad_inc;

  // Counter increment widened past CNT_W, clamped to all-ones.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [SUM_W-1:0] inc);
    logic [SUM_W-1:0] s;
    s = SUM_W'(a) + inc;
    if (s > SUM_W'(CNT_MAX)) begin
      return CNT_MAX;
    end
    return CNT_W'(s);
  endfunction

  assign din_w    = 32'(DIN);
  assign diff_w   = din_w ^ exp_q;
  assign match_w  = (diff_w == 32'd0);
  assign din_zero = (din_w == 32'd0);
  assign good_inc = good_q + GOOD_W'(1);
  assign bad_inc  = bad_q + BAD_W'(1);

  // Bit-error weight of the current word against the reference.
  popcount32 u_popcount (
    .data_i  (diff_w),
    .count_o (diff_bits)
  );

  // Next-state, reference advance and error accounting.
  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    good_d  = good_q;
    bad_d   = bad_q;
    err_d   = 1'b0;
    wcnt_d  = wcnt_q;
    bcnt_d  = bcnt_q;

    if (DIN_VLD) begin
      unique case (state_q)
        HUNT: begin
          // All-zero is the LFSR lock-up word and cannot seed a sequence.
          if (!din_zero) begin
            exp_d   = lfsr32_next(din_w);
            good_d  = '0;
            state_d = VERIFY;
          end
        end

        VERIFY: begin
          if (match_w) begin
            exp_d  = lfsr32_next(exp_q);
            good_d = good_inc;
            if (good_inc == LOCK_TGT) begin
              state_d = lfsr_pkg::LOCKED;
              bad_d   = '0;
            end
          end else if (din_zero) begin
            good_d  = '0;
            state_d = HUNT;
          end else begin
            exp_d  = lfsr32_next(din_w);
            good_d = '0;
          end
        end

        lfsr_pkg::LOCKED: begin
          // Flywheel: the reference never reseeds from received data here.
          exp_d = lfsr32_next(exp_q);
          if (match_w) begin
            bad_d = '0;
          end else begin
            err_d  = 1'b1;
            wcnt_d = sat_add(wcnt_q, SUM_W'(1));
            bcnt_d = sat_add(bcnt_q, SUM_W'(diff_bits));
            bad_d  = bad_inc;
            if (bad_inc == UNLOCK_TGT) begin
              state_d = HUNT;
            end
          end
        end

        default: begin
          state_d = HUNT;
        end
      endcase
    end

    // Clear takes priority over a coincident increment.
    if (CLR_CNT) begin
      wcnt_d = '0;
      bcnt_d = '0;
    end

    locked_d = (state_d == lfsr_pkg::LOCKED);
  end

  // State, reference and output registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= HUNT;
      exp_q    <= '0;
      good_q   <= '0;
      bad_q    <= '0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      wcnt_q   <= '0;
      bcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      exp_q    <= exp_d;
      good_q   <= good_d;
      bad_q    <= bad_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      wcnt_q   <= wcnt_d;
      bcnt_q   <= bcnt_d;
    end
  end

  assign LOCKED   = locked_q;
  assign ERR      = err_q;
  assign ERR_WCNT = wcnt_q;
  assign ERR_BCNT = bcnt_q;

endmodule
